// File: rtl/exec_datapath.sv
// exec_datapath: combinational 8-bit ALU with flag outputs, an 8-bit
// accumulator-style counter register and a single stored bit that can feed
// back into the ALU as shift/carry-in.
// Optional build macro EXEC_CYCLE_COUNT_EN adds a Halt input and a 16-bit
// free-running CycleCount output.
module exec_datapath (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] InputA,
    input  logic [7:0] InputB,
    input  logic [3:0] OP,
    input  logic [2:0] Imm,
    input  logic       UseBit,
    input  logic       CtrWriteEn,
    input  logic [1:0] CtrMode,
    input  logic       BitWriteEn,
    input  logic [1:0] BitSel,
`ifdef EXEC_CYCLE_COUNT_EN
    input  logic        Halt,
    output logic [15:0] CycleCount,
`endif
    output logic [7:0] Out,
    output logic       Zero,
    output logic       Parity,
    output logic       OutBit,
    output logic [7:0] CtrOut,
    output logic       BitOut
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_GETB  = 4'd8;
    localparam logic [3:0] OP_SETB  = 4'd9;
    localparam logic [3:0] OP_CLRB  = 4'd10;
    localparam logic [3:0] OP_PASSA = 4'd11;
    localparam logic [3:0] OP_PASSB = 4'd12;
    localparam logic [3:0] OP_INC   = 4'd13;
    localparam logic [3:0] OP_DEC   = 4'd14;

    logic [7:0] r_ctr;
    logic       r_bit;

    logic       w_sc;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [8:0] w_inc;
    logic [7:0] w_mask;
    logic [7:0] w_out;
    logic       w_outbit;
    logic       w_bit_next;

    // Carry/shift-in comes from the stored bit only when requested.
    assign w_sc   = UseBit & r_bit;

    // 9-bit arithmetic so bit 8 carries the carry/borrow out of the byte.
    assign w_sum  = {1'b0, InputA} + {1'b0, InputB} + {8'd0, w_sc};
    assign w_diff = {1'b0, InputA} - {1'b0, InputB} - {8'd0, w_sc};
    assign w_inc  = {1'b0, InputA} + 9'd1;
    assign w_mask = 8'd1 << Imm;

    // ALU result and side bit; every opcode not listed yields zero.
    always_comb begin
        w_out    = 8'h00;
        w_outbit = 1'b0;
        case (OP)
            OP_ADD: begin
                w_out    = w_sum[7:0];
                w_outbit = w_sum[8];
            end
            OP_SUB: begin
                w_out    = w_diff[7:0];
                w_outbit = w_diff[8];
            end
            OP_AND:   w_out = InputA & InputB;
            OP_OR:    w_out = InputA | InputB;
            OP_XOR:   w_out = InputA ^ InputB;
            OP_NOT:   w_out = ~InputA;
            OP_SHL: begin
                w_out    = {InputA[6:0], w_sc};
                w_outbit = InputA[7];
            end
            OP_SHR: begin
                w_out    = {w_sc, InputA[7:1]};
                w_outbit = InputA[0];
            end
            OP_GETB: begin
                w_out    = InputA;
                w_outbit = InputA[Imm];
            end
            OP_SETB:  w_out = InputA | w_mask;
            OP_CLRB:  w_out = InputA & ~w_mask;
            OP_PASSA: w_out = InputA;
            OP_PASSB: w_out = InputB;
            OP_INC: begin
                w_out    = w_inc[7:0];
                w_outbit = w_inc[8];
            end
            OP_DEC: begin
                w_out    = InputA - 8'd1;
                w_outbit = (InputA == 8'h00);
            end
            default: begin
                w_out    = 8'h00;
                w_outbit = 1'b0;
            end
        endcase
    end

    assign Out    = w_out;
    assign OutBit = w_outbit;
    assign Zero   = (w_out == 8'h00);
    assign Parity = ^w_out;

    // Bit-store source select; unused encodings store zero.
    always_comb begin
        w_bit_next = 1'b0;
        case (BitSel)
            2'b01:   w_bit_next = Parity;
            2'b10:   w_bit_next = w_outbit;
            default: w_bit_next = 1'b0;
        endcase
    end

    // Counter register: load, increment, decrement or accumulate ALU result.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ctr <= 8'h00;
        end else if (CtrWriteEn) begin
            case (CtrMode)
                2'b00:   r_ctr <= w_out;
                2'b01:   r_ctr <= r_ctr + 8'd1;
                2'b10:   r_ctr <= r_ctr - 8'd1;
                default: r_ctr <= r_ctr + w_out;
            endcase
        end
    end

    // Stored bit register; sampled alongside the counter from pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_bit <= 1'b0;
        end else if (BitWriteEn) begin
            r_bit <= w_bit_next;
        end
    end

    assign CtrOut = r_ctr;
    assign BitOut = r_bit;

`ifdef EXEC_CYCLE_COUNT_EN
    logic [15:0] r_cycles;

    // Free-running edge counter, frozen while halted, wraps naturally.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cycles <= 16'h0000;
        end else if (!Halt) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign CycleCount = r_cycles;
`endif

endmodule

// File: tb/tb_exec_datapath.sv
// Directed-vector bench for exec_datapath; expected values are hand-derived.
module tb_exec_datapath;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] InputA, InputB;
    logic [3:0] OP;
    logic [2:0] Imm;
    logic       UseBit, CtrWriteEn, BitWriteEn;
    logic [1:0] CtrMode, BitSel;
    logic [7:0] Out, CtrOut;
    logic       Zero, Parity, OutBit, BitOut;
`ifdef EXEC_CYCLE_COUNT_EN
    logic        Halt;
    logic [15:0] CycleCount;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    exec_datapath dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .InputA     (InputA),
        .InputB     (InputB),
        .OP         (OP),
        .Imm        (Imm),
        .UseBit     (UseBit),
        .CtrWriteEn (CtrWriteEn),
        .CtrMode    (CtrMode),
        .BitWriteEn (BitWriteEn),
        .BitSel     (BitSel),
`ifdef EXEC_CYCLE_COUNT_EN
        .Halt       (Halt),
        .CycleCount (CycleCount),
`endif
        .Out        (Out),
        .Zero       (Zero),
        .Parity     (Parity),
        .OutBit     (OutBit),
        .CtrOut     (CtrOut),
        .BitOut     (BitOut)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply an ALU operation and let the combinational outputs settle.
    task automatic alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] imm, input logic ub);
        OP = op; InputA = a; InputB = b; Imm = imm; UseBit = ub;
        #1;
    endtask

    // Advance one rising edge and sample shortly after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        InputA = 8'h00; InputB = 8'h00; OP = 4'd0; Imm = 3'd0; UseBit = 1'b0;
        CtrWriteEn = 1'b0; CtrMode = 2'b00; BitWriteEn = 1'b0; BitSel = 2'b00;
`ifdef EXEC_CYCLE_COUNT_EN
        Halt = 1'b0;
`endif
        #2;
        chk("reset_ctr", {8'h00, CtrOut}, 16'h0000);
        chk("reset_bit", {15'h0, BitOut}, 16'h0000);
        tick();
        tick();
        Reset = 1'b0;

        // ADD with carry out to zero
        alu(4'd0, 8'hFF, 8'h01, 3'd0, 1'b0);
        chk("add_out", {8'h00, Out}, 16'h0000);
        chk("add_zero", {15'h0, Zero}, 16'h0001);
        chk("add_carry", {15'h0, OutBit}, 16'h0001);
        chk("add_par", {15'h0, Parity}, 16'h0000);

        // GETB into bit store, then SHL with stored bit as shift-in
        alu(4'd8, 8'h80, 8'h00, 3'd7, 1'b0);
        BitSel = 2'b10; BitWriteEn = 1'b1;
        #1;
        chk("getb_outbit", {15'h0, OutBit}, 16'h0001);
        chk("getb_out", {8'h00, Out}, 16'h0080);
        tick();
        BitWriteEn = 1'b0;
        chk("getb_stored", {15'h0, BitOut}, 16'h0001);
        alu(4'd6, 8'h01, 8'h00, 3'd0, 1'b1);
        chk("shl_out", {8'h00, Out}, 16'h0003);
        chk("shl_outbit", {15'h0, OutBit}, 16'h0000);
        alu(4'd7, 8'h81, 8'h00, 3'd0, 1'b1);
        chk("shr_out", {8'h00, Out}, 16'h00C0);
        chk("shr_outbit", {15'h0, OutBit}, 16'h0001);
        alu(4'd7, 8'h81, 8'h00, 3'd0, 1'b0);
        chk("shr_nosc", {8'h00, Out}, 16'h0040);

        // ADD with carry-in, then simultaneous counter/bit writes
        alu(4'd0, 8'h01, 8'h01, 3'd0, 1'b1);
        chk("addc_out", {8'h00, Out}, 16'h0003);
        CtrWriteEn = 1'b1; CtrMode = 2'b00; BitWriteEn = 1'b1; BitSel = 2'b10;
        tick();
        CtrWriteEn = 1'b0; BitWriteEn = 1'b0;
        chk("simul_ctr", {8'h00, CtrOut}, 16'h0003);
        chk("simul_bit", {15'h0, BitOut}, 16'h0000);

        // Counter load/increment/decrement/accumulate with wrap
        alu(4'd12, 8'h00, 8'hFE, 3'd0, 1'b0);
        CtrWriteEn = 1'b1; CtrMode = 2'b00;
        tick();
        chk("ctr_load", {8'h00, CtrOut}, 16'h00FE);
        CtrMode = 2'b01;
        tick();
        chk("ctr_inc1", {8'h00, CtrOut}, 16'h00FF);
        tick();
        chk("ctr_inc_wrap", {8'h00, CtrOut}, 16'h0000);
        CtrMode = 2'b10;
        tick();
        chk("ctr_dec_wrap", {8'h00, CtrOut}, 16'h00FF);
        CtrWriteEn = 1'b0;
        tick();
        chk("ctr_hold", {8'h00, CtrOut}, 16'h00FF);
        alu(4'd11, 8'h03, 8'h00, 3'd0, 1'b0);
        CtrWriteEn = 1'b1; CtrMode = 2'b11;
        tick();
        CtrWriteEn = 1'b0;
        chk("ctr_acc", {8'h00, CtrOut}, 16'h0002);

        // Bitwise ops and parity-sourced bit store
        alu(4'd2, 8'hF0, 8'h3C, 3'd0, 1'b0);
        chk("and_out", {8'h00, Out}, 16'h0030);
        alu(4'd3, 8'hF0, 8'h3C, 3'd0, 1'b0);
        chk("or_out", {8'h00, Out}, 16'h00FC);
        alu(4'd5, 8'h0F, 8'h00, 3'd0, 1'b0);
        chk("not_out", {8'h00, Out}, 16'h00F0);
        alu(4'd4, 8'h07, 8'h00, 3'd0, 1'b0);
        chk("xor_out", {8'h00, Out}, 16'h0007);
        chk("xor_par", {15'h0, Parity}, 16'h0001);
        BitWriteEn = 1'b1; BitSel = 2'b01;
        tick();
        chk("par_stored", {15'h0, BitOut}, 16'h0001);
        BitSel = 2'b11;
        tick();
        chk("sel11_clear", {15'h0, BitOut}, 16'h0000);
        BitSel = 2'b01;
        tick();
        BitWriteEn = 1'b0;
        chk("par_restored", {15'h0, BitOut}, 16'h0001);
        tick();
        chk("bit_hold", {15'h0, BitOut}, 16'h0001);

        // SUB borrow and SUB with borrow-in
        alu(4'd1, 8'h00, 8'h01, 3'd0, 1'b0);
        chk("sub_out", {8'h00, Out}, 16'h00FF);
        chk("sub_borrow", {15'h0, OutBit}, 16'h0001);
        alu(4'd1, 8'h05, 8'h02, 3'd0, 1'b1);
        chk("subc_out", {8'h00, Out}, 16'h0002);
        chk("subc_borrow", {15'h0, OutBit}, 16'h0000);
        alu(4'd1, 8'h00, 8'hFF, 3'd0, 1'b1);
        chk("sub_full_borrow", {8'h00, Out} | {7'h0, OutBit, 8'h00}, 16'h0100);

        // Bit manipulation, INC/DEC edges, ZERO
        alu(4'd9, 8'h00, 8'h00, 3'd3, 1'b0);
        chk("setb_out", {8'h00, Out}, 16'h0008);
        alu(4'd10, 8'hFF, 8'h00, 3'd0, 1'b0);
        chk("clrb_out", {8'h00, Out}, 16'h00FE);
        alu(4'd13, 8'hFF, 8'h00, 3'd0, 1'b0);
        chk("inc_wrap", {7'h0, OutBit, Out}, 16'h0100);
        alu(4'd14, 8'h00, 8'h00, 3'd0, 1'b0);
        chk("dec_wrap", {7'h0, OutBit, Out}, 16'h01FF);
        alu(4'd14, 8'h01, 8'h00, 3'd0, 1'b0);
        chk("dec_plain", {7'h0, OutBit, Out}, 16'h0000);
        alu(4'd15, 8'hFF, 8'hFF, 3'd0, 1'b0);
        chk("zero_op", {6'h0, Zero, OutBit, Out}, 16'h0200);
        alu(4'd12, 8'h00, 8'h81, 3'd0, 1'b0);
        chk("passb_par", {7'h0, Parity, Out}, 16'h0081);

        // Asynchronous reset between edges, overriding enables
        alu(4'd11, 8'h55, 8'h00, 3'd0, 1'b0);
        CtrWriteEn = 1'b1; CtrMode = 2'b00;
        tick();
        chk("pre_reset_ctr", {8'h00, CtrOut}, 16'h0055);
        chk("pre_reset_bit", {15'h0, BitOut}, 16'h0001);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("async_rst_ctr", {8'h00, CtrOut}, 16'h0000);
        chk("async_rst_bit", {15'h0, BitOut}, 16'h0000);
        tick();
        chk("rst_overrides_en", {8'h00, CtrOut}, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        CtrWriteEn = 1'b0;
        chk("first_edge_after_rst", {8'h00, CtrOut}, 16'h0055);

`ifdef EXEC_CYCLE_COUNT_EN
        @(negedge Clk);
        Reset = 1'b1; Halt = 1'b0;
        #1;
        chk("cyc_reset", CycleCount, 16'h0000);
        Reset = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        Halt = 1'b1;
        chk("cyc_ten", CycleCount, 16'd10);
        tick();
        tick();
        tick();
        chk("cyc_held", CycleCount, 16'd10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
